// File: rtl/switch_arb_pkg.sv
// Shared types and constants for the switch ingress arbiter and its picker.
package switch_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int unsigned SW_ADDR_W = 8;
  localparam int unsigned SW_DATA_W = 16;
  localparam int unsigned STATS_W   = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set request after i_last_owner, wrapping.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last_owner,
  output logic [IW-1:0] o_winner,
  output logic          o_any_req
);

  int unsigned w_idx;

  always_comb begin
    o_winner  = '0;
    o_any_req = 1'b0;
    w_idx     = 0;
    for (int unsigned off = 1; off <= N; off++) begin
      w_idx = (32'(i_last_owner) + off) % N;
      if (!o_any_req && i_req[IW'(w_idx)]) begin
        o_winner  = IW'(w_idx);
        o_any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_ingress_arb.sv
// Round-robin ingress arbiter with bounded bursts in front of the two-port switch.
// Optional per-requester beat counters are built when SWITCH_ARB_STATS_EN is defined.
module switch_ingress_arb
  import switch_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ADDR_W    = SW_ADDR_W,
  parameter int unsigned DATA_W    = SW_DATA_W,
  parameter int unsigned MAX_BURST = 4,
  localparam int unsigned IW       = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [NUM_REQ-1:0]          req_vld,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_rdy,
  input  logic                        hold,
  output logic [ADDR_W-1:0]           addr,
  output logic [DATA_W-1:0]           data,
  output logic                        vld,
  output logic [IW-1:0]               gnt_id,
`ifdef SWITCH_ARB_STATS_EN
  input  logic                        stats_clr,
  output logic [NUM_REQ*STATS_W-1:0]  gnt_count,
`endif
  output logic                        busy
);

  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  arb_state_t        r_state;
  logic [IW-1:0]     r_owner;
  logic [IW-1:0]     r_last_owner;
  logic [IW-1:0]     r_gnt_id;
  logic [3:0]        r_burst_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_vld;
  logic              r_busy;

  logic [IW-1:0]     w_winner;
  logic              w_any_req;
  logic              w_owner_vld;
  logic              w_accept;
  logic [ADDR_W-1:0] w_own_addr;
  logic [DATA_W-1:0] w_own_data;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .i_req        (req_vld),
    .i_last_owner (r_last_owner),
    .o_winner     (w_winner),
    .o_any_req    (w_any_req)
  );

  always_comb begin
    w_owner_vld = 1'b0;
    w_own_addr  = '0;
    w_own_data  = '0;
    req_rdy     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (r_owner == IW'(i)) begin
        w_owner_vld = req_vld[i];
        w_own_addr  = req_addr[i*ADDR_W +: ADDR_W];
        w_own_data  = req_data[i*DATA_W +: DATA_W];
        req_rdy[i]  = (r_state == GRANT) && !hold;
      end
    end
  end

  assign w_accept = (r_state == GRANT) && !hold && w_owner_vld;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_owner      <= '0;
      r_last_owner <= IW'(NUM_REQ - 1);
      r_gnt_id     <= '0;
      r_burst_cnt  <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_vld        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_vld <= w_accept;
      if (w_accept) begin
        r_addr <= w_own_addr;
        r_data <= w_own_data;
      end
      unique case (r_state)
        IDLE: begin
          if (!hold && w_any_req) begin
            r_state     <= GRANT;
            r_owner     <= w_winner;
            r_gnt_id    <= w_winner;
            r_burst_cnt <= '0;
            r_busy      <= 1'b1;
          end
        end
        GRANT: begin
          // hold freezes the grant entirely, including a dropped owner valid
          if (!hold) begin
            if (!w_owner_vld || r_burst_cnt == BURST_LAST) begin
              r_state      <= IDLE;
              r_last_owner <= r_owner;
              r_busy       <= 1'b0;
            end
            if (w_owner_vld) begin
              r_burst_cnt <= r_burst_cnt + 4'd1;
            end
          end
        end
      endcase
    end
  end

  assign addr   = r_addr;
  assign data   = r_data;
  assign vld    = r_vld;
  assign gnt_id = r_gnt_id;
  assign busy   = r_busy;

`ifdef SWITCH_ARB_STATS_EN
  logic [STATS_W-1:0] r_gnt_count [NUM_REQ];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) r_gnt_count[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (stats_clr) begin
          r_gnt_count[i] <= '0;
        end else if (w_accept && r_owner == IW'(i) && r_gnt_count[i] != '1) begin
          r_gnt_count[i] <= r_gnt_count[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt_count = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      gnt_count[i*STATS_W +: STATS_W] = r_gnt_count[i];
    end
  end
`endif

endmodule

// File: tb/tb_switch_ingress_arb.sv
// Scoreboard bench for switch_ingress_arb: source queues drive requesters, a monitor checks beats.
module tb_switch_ingress_arb;

  localparam int unsigned NR = 4;

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
  } beat_t;

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
    logic [1:0]  id;
  } exp_t;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [NR-1:0]  req_vld = '0;
  logic [NR*8-1:0]  req_addr = '0;
  logic [NR*16-1:0] req_data = '0;
  logic [NR-1:0]  req_rdy;
  logic           hold = 1'b0;
  logic [7:0]     addr;
  logic [15:0]    data;
  logic           vld;
  logic [1:0]     gnt_id;
  logic           busy;
`ifdef SWITCH_ARB_STATS_EN
  logic           stats_clr = 1'b0;
  logic [NR*16-1:0] gnt_count;
`endif

  beat_t src_q [NR][$];
  exp_t  exp_q [$];
  logic [31:0] vld_hist = '0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  switch_ingress_arb #(
    .NUM_REQ   (4),
    .ADDR_W    (8),
    .DATA_W    (16),
    .MAX_BURST (4)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_vld   (req_vld),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_rdy   (req_rdy),
    .hold      (hold),
    .addr      (addr),
    .data      (data),
    .vld       (vld),
    .gnt_id    (gnt_id),
`ifdef SWITCH_ARB_STATS_EN
    .stats_clr (stats_clr),
    .gnt_count (gnt_count),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Requester model: present queue head at negedge, retire it if accepted just before posedge.
  always begin
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() > 0) begin
        req_vld[i] = 1'b1;
        req_addr[i*8 +: 8]   = src_q[i][0].a;
        req_data[i*16 +: 16] = src_q[i][0].d;
      end else begin
        req_vld[i] = 1'b0;
      end
    end
    #4;
    for (int i = 0; i < NR; i++) begin
      if (rstn && req_vld[i] && req_rdy[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
  end

  always @(negedge clk) begin
    vld_hist = {vld_hist[30:0], vld};
    if (vld) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {8'h0, addr, data}, 32'hDEAD_0000);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("beat_addr", 32'(addr), 32'(e.a));
        chk("beat_data", 32'(data), 32'(e.d));
        chk("beat_gnt_id", 32'(gnt_id), 32'(e.id));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int unsigned r, input logic [7:0] a, input logic [15:0] d);
    beat_t b;
    exp_t  e;
    b.a = a; b.d = d;
    e.a = a; e.d = d; e.id = 2'(r);
    src_q[r].push_back(b);
    exp_q.push_back(e);
  endtask

  function automatic bit srcs_pending();
    for (int i = 0; i < NR; i++) if (src_q[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] norm(input logic [31:0] h);
    logic [31:0] v;
    v = h;
    for (int i = 0; i < 32; i++) if (v != 0 && v[0] == 1'b0) v = v >> 1;
    return v;
  endfunction

  task automatic wait_drain(input string name);
    int unsigned n;
    n = 0;
    while ((exp_q.size() != 0 || srcs_pending()) && n < 400) begin
      step();
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_q.size());
    end
    repeat (3) step();
  endtask

  task automatic wait_busy(input string name);
    int unsigned n;
    n = 0;
    while (!busy && n < 50) begin
      step();
      n++;
    end
    chk(name, 32'(busy), 32'd1);
  endtask

  task automatic wait_src_size(input int unsigned r, input int unsigned sz, input string name);
    int unsigned n;
    n = 0;
    while (src_q[r].size() != sz && n < 50) begin
      step();
      n++;
    end
    chk(name, src_q[r].size(), sz);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    hold = 1'b0;
`ifdef SWITCH_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    for (int i = 0; i < NR; i++) src_q[i].delete();
    exp_q.delete();
    repeat (3) step();
    rstn = 1'b1;
    step();
    vld_hist = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and single-requester streaming
    do_reset();
    chk("rst_vld", 32'(vld), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt_id", 32'(gnt_id), 32'd0);
    chk("rst_req_rdy", 32'(req_rdy), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    for (int k = 0; k < 8; k++) send(0, 8'(8'h10 + k), 16'(16'hA000 + k));
    wait_drain("stream0");
    chk("stream0_vld_pattern", norm(vld_hist), 32'h1EF);
    chk("stream0_gnt_id", 32'(gnt_id), 32'd0);
    chk("stream0_busy_end", 32'(busy), 32'd0);

    // All four requesting: rotation 0,1,2,3,0 with one bubble between grants
    do_reset();
    for (int i = 0; i < NR; i++)
      for (int k = 0; k < 4; k++) send(i, 8'(8'h40 + i*16 + k), 16'(16'hB000 + i*256 + k));
    for (int k = 4; k < 8; k++) send(0, 8'(8'h40 + k), 16'(16'hB000 + k));
    wait_drain("rotate");
    chk("rotate_vld_pattern", norm(vld_hist), 32'hF7BDEF);
    chk("rotate_gnt_id_end", 32'(gnt_id), 32'd0);

    // Requester 2 drops after 2 beats; 3 wins next, then wrap to 0
    do_reset();
    send(2, 8'h20, 16'hC000);
    send(2, 8'h21, 16'hC001);
    wait_busy("drop_grant2");
    chk("drop_gnt_id2", 32'(gnt_id), 32'd2);
    send(3, 8'h30, 16'hC300);
    send(0, 8'h00, 16'hC400);
    wait_drain("drop");
    chk("drop_gnt_id_end", 32'(gnt_id), 32'd0);

    // hold for 3 cycles after beat 2 of a 4-beat burst
    do_reset();
    for (int k = 0; k < 4; k++) send(1, 8'(8'h50 + k), 16'(16'hD000 + k));
    wait_src_size(1, 2, "hold_two_beats");
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hold_vld", 32'(vld), 32'd0);
      chk("hold_req_rdy", 32'(req_rdy), 32'd0);
      chk("hold_busy", 32'(busy), 32'd1);
    end
    hold = 1'b0;
    wait_drain("hold");
    chk("hold_vld_pattern", norm(vld_hist), 32'h63);

    // Reset during beat 3 of requester 1's burst
    do_reset();
    src_q[1].push_back('{a: 8'h60, d: 16'hE000});
    src_q[1].push_back('{a: 8'h61, d: 16'hE001});
    src_q[1].push_back('{a: 8'h62, d: 16'hE002});
    src_q[1].push_back('{a: 8'h63, d: 16'hE003});
    exp_q.push_back('{a: 8'h60, d: 16'hE000, id: 2'd1});
    exp_q.push_back('{a: 8'h61, d: 16'hE001, id: 2'd1});
    wait_src_size(1, 2, "rst_mid_two_beats");
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_mid_vld", 32'(vld), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_req_rdy", 32'(req_rdy), 32'd0);
    chk("rst_mid_outstanding", exp_q.size(), 32'd0);
    src_q[1].delete();
    repeat (2) step();
    rstn = 1'b1;
    step();
    send(0, 8'h70, 16'hF000);
    send(1, 8'h71, 16'hF100);
    wait_drain("rst_mid");

`ifdef SWITCH_ARB_STATS_EN
    do_reset();
    for (int k = 0; k < 10; k++) send(1, 8'(8'h80 + k), 16'(16'h1000 + k));
    wait_drain("stats");
    chk("stats_cnt0", 32'(gnt_count[15:0]), 32'd0);
    chk("stats_cnt1", 32'(gnt_count[31:16]), 32'd10);
    chk("stats_cnt2", 32'(gnt_count[47:32]), 32'd0);
    chk("stats_cnt3", 32'(gnt_count[63:48]), 32'd0);
    send(1, 8'h8A, 16'h100A);
    wait_busy("stats_clr_grant");
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    chk("stats_clr_wins", 32'(gnt_count[31:16]), 32'd0);
    wait_drain("stats_clr");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_ingress_arb.md
Name: switch_ingress_arb

Overview:
- Round-robin arbiter that shares the single ingress port (addr/data/vld) of the two-port switch among NUM_REQ requesters.
- Each requester gets a valid/ready handshake. Grants are bounded bursts of at most MAX_BURST beats.
- Sits directly in front of the switch. Its registered outputs drive the switch's addr, data and vld inputs.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- ADDR_W, 8: address width, matches the switch addr.
- DATA_W, 16: data width, matches the switch data.
- MAX_BURST, 4: maximum beats per grant (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_vld  in  NUM_REQ  per-requester beat valid.
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*DATA_W  flattened data; same packing as req_addr.
- req_rdy  out  NUM_REQ  per-requester ready (one-hot or zero).
- hold  in  1  freeze forwarding when high.
- addr  out  ADDR_W  to switch addr.
- data  out  DATA_W  to switch data.
- vld  out  1  to switch vld.
- gnt_id  out  $clog2(NUM_REQ)  current or last owner.
- busy  out  1  high while in GRANT.

Behaviour:
- Reset values (async, rstn low):
  - state=IDLE, addr=0, data=0, vld=0, gnt_id=0, busy=0, burst_cnt=0.
  - last_owner=NUM_REQ-1, so requester 0 has first priority.
  - All req_rdy=0.
- States: IDLE, GRANT.
- IDLE, with hold=0 and any req_vld:
  - Winner = first set bit of req_vld scanning from last_owner+1 upward, wrapping modulo NUM_REQ.
  - Next cycle: state=GRANT, owner=winner, gnt_id=winner, burst_cnt=0, busy=1.
  - This costs exactly one arbitration bubble cycle.
- IDLE, with no requests or hold=1: stay in IDLE.
- req_rdy is combinational: req_rdy[i] = (state==GRANT) && owner==i && !hold.
- A beat is accepted when req_vld[owner] && req_rdy[owner].
- Accepted beat in cycle t:
  - addr/data take the owner's fields and vld=1 at edge t+1, i.e. one-cycle latency.
  - burst_cnt increments.
- Cycles with no accepted beat: vld=0 next edge; addr/data hold their last values.
- Leaving GRANT → IDLE happens at the edge where either:
  - burst_cnt reaches MAX_BURST (the MAX_BURST-th beat is accepted), or
  - req_vld[owner]=0 while hold=0.
  - On exit: last_owner=owner, busy=0; gnt_id keeps its value.
- hold=1 in GRANT: state, owner and burst_cnt are frozen; no beat is accepted; vld=0. A dropped req_vld during hold does not end the grant.
- Non-owner req_vld is ignored during GRANT. Requesters must hold vld and payload stable until accepted.
- Single requester streaming continuously: MAX_BURST beats, 1 bubble, MAX_BURST beats, and so on.
- Reset mid-burst: the in-flight beat is dropped, vld goes low immediately, and arbitration restarts at requester 0.
- burst_cnt width is 4 bits and never exceeds MAX_BURST.

Optional Feature:
- Macro: SWITCH_ARB_STATS_EN.
- When defined:
  - Adds output gnt_count (NUM_REQ*16 bits): one 16-bit beat counter per requester.
  - Each counter increments on every accepted beat of that requester and saturates at 16'hFFFF.
  - Adds input stats_clr (1 bit): synchronous clear of all counters; clr wins over a simultaneous increment.
  - All counters reset to 0 on rstn.
- When undefined: neither port exists, no counter logic is built, and all other behaviour is identical.

Decomposition:
- Package switch_arb_pkg holds:
  - the state enum (IDLE, GRANT);
  - default ADDR_W=8 and DATA_W=16 constants shared with the switch;
  - the STATS_W=16 constant.
- One sub-module, rr_pick: purely combinational rotate-priority picker.
  - Inputs: req vector, last_owner.
  - Outputs: winner index, any_req.
  - Reusable by other switch arbiters.

Test Plan:
- Reset, then req_vld=4'b0001 with addresses 8'h10..8'h17 streamed → vld pattern 1111 0 1111, beats in order, gnt_id=0.
- req_vld=4'b1111 held continuously, MAX_BURST=4 → grants rotate 0,1,2,3,0; each grant gives 4 beats with a 1-cycle gap between grants.
- Requester 2 sends 2 beats and then drops req_vld → grant ends after 2 beats; next winner is 3 if requesting, else wraps to 0.
- hold=1 for 3 cycles mid-burst after beat 2 → vld=0 and req_rdy=0 for those 3 cycles; after release, exactly 2 more beats complete the 4-beat burst.
- rstn pulsed low during beat 3 of requester 1's burst → vld=0 asynchronously; after release with req_vld=4'b0011, requester 0 is granted first.
- With SWITCH_ARB_STATS_EN: 10 beats from requester 1 → gnt_count[1]=10, others 0; stats_clr asserted on the same cycle as a beat → counter reads 0.
